// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path: FSM state encoding,
// the sampling-point offset helper and frame-length constants.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int START_BITS = 1;
  localparam int STOP_BITS  = 1;
  localparam int PAR_BITS   = 1;
  localparam int BIT_CNT_W  = 4;

  // Oversample edge at which a sampled bit is stable at the sampler output.
  function automatic int chk_edge(input int prescale);
    return prescale / 2 + 2;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl.sv
// Frame-sequencing controller for the UART receiver; drives counter, sampler,
// deserializer and checker enables. Optional error flags: UART_RX_ERR_FLAGS_EN.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE  = 8,
  parameter int EDGE_W    = 3,
  parameter int DATA_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_IN,
  input  logic                 PAR_EN,
  input  logic [EDGE_W-1:0]    edge_cnt,
  input  logic [BIT_CNT_W-1:0] bit_cnt,
  input  logic                 strt_glitch,
  input  logic                 par_err,
  input  logic                 stp_err,
  output logic                 cnt_en,
  output logic                 dat_samp_en,
  output logic                 deser_en,
  output logic                 strt_chk_en,
  output logic                 par_chk_en,
  output logic                 stp_chk_en,
  output logic                 data_valid,
  output logic                 par_err_flag,
  output logic                 stp_err_flag
);

  localparam int CHK = chk_edge(PRESCALE);
  // Strobes are registered, so they are launched one edge before CHK.
  localparam logic [EDGE_W-1:0]    EDGE_STROBE   = EDGE_W'(CHK - 1);
  localparam logic [EDGE_W-1:0]    EDGE_EVAL     = EDGE_W'(CHK + 1);
  localparam logic [EDGE_W-1:0]    EDGE_LAST     = EDGE_W'(PRESCALE - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_BITS);

  rx_state_t state_q;
  logic busy_q, deser_q, strt_q, par_chk_q, stp_chk_q, valid_q;
  logic par_en_q, perr_q;

  logic strobe_edge_s, eval_edge_s, last_edge_s, start_entry_s, frame_eval_s;

  assign strobe_edge_s = (edge_cnt == EDGE_STROBE);
  assign eval_edge_s   = (edge_cnt == EDGE_EVAL);
  assign last_edge_s   = (edge_cnt == EDGE_LAST);
  assign start_entry_s = (state_q == IDLE) && !RX_IN;
  assign frame_eval_s  = (state_q == STOP) && eval_edge_s;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      deser_q   <= 1'b0;
      strt_q    <= 1'b0;
      par_chk_q <= 1'b0;
      stp_chk_q <= 1'b0;
      valid_q   <= 1'b0;
      par_en_q  <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      deser_q   <= 1'b0;
      strt_q    <= 1'b0;
      par_chk_q <= 1'b0;
      stp_chk_q <= 1'b0;
      valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_entry_s) begin
            state_q  <= START;
            busy_q   <= 1'b1;
            par_en_q <= PAR_EN;
            perr_q   <= 1'b0;
          end
        end
        START: begin
          strt_q <= strobe_edge_s;
          if (eval_edge_s && strt_glitch) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (last_edge_s) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          deser_q <= strobe_edge_s;
          if (last_edge_s && (bit_cnt == LAST_DATA_BIT)) begin
            state_q <= par_en_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_chk_q <= strobe_edge_s;
          if (eval_edge_s) begin
            perr_q <= par_err;
          end
          if (last_edge_s) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          stp_chk_q <= strobe_edge_s;
          // Leaving mid-stop-bit lets a back-to-back start edge be caught.
          if (eval_edge_s) begin
            valid_q <= !stp_err && !perr_q;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_ERR_FLAGS_EN
  logic par_flag_q, stp_flag_q;

  // Sticky error flags, cleared when a new frame starts.
  always_ff @(posedge CLK) begin
    if (RST || start_entry_s) begin
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
    end else if (frame_eval_s) begin
      if (perr_q) par_flag_q <= 1'b1;
      if (stp_err) stp_flag_q <= 1'b1;
    end
  end

  assign par_err_flag = par_flag_q;
  assign stp_err_flag = stp_flag_q;
`else
  assign par_err_flag = 1'b0;
  assign stp_err_flag = 1'b0;
`endif

  assign cnt_en      = busy_q;
  assign dat_samp_en = busy_q;
  assign deser_en    = deser_q;
  assign strt_chk_en = strt_q;
  assign par_chk_en  = par_chk_q;
  assign stp_chk_en  = stp_chk_q;
  assign data_valid  = valid_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: sibling counter/checker models, a
// frame-level event scoreboard, directed scenarios and randomized frames.
module tb_uart_rx_ctrl;

  localparam int P   = 8;
  localparam int EW  = 3;
  localparam int DB  = 8;
  localparam int CHK = P / 2 + 2;
`ifdef UART_RX_ERR_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST, RX_IN, PAR_EN;
  logic [EW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          strt_glitch, par_err, stp_err;
  logic          cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic          data_valid, par_err_flag, stp_err_flag;

  uart_rx_ctrl #(.PRESCALE(P), .EDGE_W(EW), .DATA_BITS(DB)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .cnt_en(cnt_en), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .data_valid(data_valid), .par_err_flag(par_err_flag), .stp_err_flag(stp_err_flag)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  bit inj_glitch = 1'b0, inj_perr = 1'b0, inj_serr = 1'b0;

  // Sibling blocks: edge/bit counter and checkers answering one cycle after their strobe.
  always @(posedge CLK) begin
    if (RST || !cnt_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      edge_cnt <= edge_cnt + 1'b1;
      if (edge_cnt == EW'(P - 1)) bit_cnt <= bit_cnt + 4'd1;
    end
    strt_glitch <= !RST && strt_chk_en && inj_glitch;
    par_err     <= !RST && par_chk_en && inj_perr;
    stp_err     <= !RST && stp_chk_en && inj_serr;
  end

  int nvec = 0, nerr = 0;
  int obs_dv[$], obs_ds[$], obs_sc[$], obs_pc[$], obs_tc[$];
  int exp_dv[$], exp_ds[$], exp_sc[$], exp_pc[$], exp_tc[$];
  int overlap = 0, samp_mis = 0;
  bit exp_pf = 1'b0, exp_sf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
            data_valid, par_err_flag, stp_err_flag};
  endfunction

  task automatic tick();
    @(negedge CLK);
    if (data_valid)  obs_dv.push_back(cyc);
    if (deser_en)    obs_ds.push_back(cyc);
    if (strt_chk_en) obs_sc.push_back(cyc);
    if (par_chk_en)  obs_pc.push_back(cyc);
    if (stp_chk_en)  obs_tc.push_back(cyc);
    if (int'(strt_chk_en) + int'(par_chk_en) + int'(stp_chk_en) > 1) overlap++;
    if (dat_samp_en !== cnt_en) samp_mis++;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cmp_q(input string tag, input int o[$], input int e[$]);
    chk({tag, "_count"}, o.size(), e.size());
    for (int i = 0; i < e.size() && i < o.size(); i++) chk(tag, o[i], e[i]);
  endtask

  task automatic verify();
    cmp_q("data_valid_cycle", obs_dv, exp_dv);
    cmp_q("deser_en_cycle", obs_ds, exp_ds);
    cmp_q("strt_chk_cycle", obs_sc, exp_sc);
    cmp_q("par_chk_cycle", obs_pc, exp_pc);
    cmp_q("stp_chk_cycle", obs_tc, exp_tc);
    chk("strobe_overlap", overlap, 0);
    chk("samp_vs_cnt_en", samp_mis, 0);
    obs_dv.delete(); obs_ds.delete(); obs_sc.delete(); obs_pc.delete(); obs_tc.delete();
    exp_dv.delete(); exp_ds.delete(); exp_sc.delete(); exp_pc.delete(); exp_tc.delete();
    overlap = 0;
    samp_mis = 0;
  endtask

  // Drives one frame starting now (cycle T = t0) and records the expected events.
  task automatic send(input logic [7:0] data, input bit par, input bit glitch,
                      input bit perr, input bit serr, input int rst_k, output int t0);
    int eval_off, len, cut;
    bit done;
    eval_off = 1 + P * (1 + DB + (par ? 1 : 0)) + CHK + 1;
    done = !glitch && (rst_k < 0);
    if (glitch) begin
      len = 10; cut = 1 + CHK;
    end else if (rst_k >= 0) begin
      len = rst_k + 2; cut = rst_k;
    end else begin
      len = eval_off + 1; cut = eval_off;
    end
    inj_glitch = glitch; inj_perr = perr; inj_serr = serr;
    t0 = 0;
    for (int k = 0; k < len; k++) begin
      int j;
      tick();
      j = k / P;
      if (k == 0) begin
        t0 = cyc;
        chk("par_flag_hold", par_err_flag, exp_pf);
        chk("stp_flag_hold", stp_err_flag, exp_sf);
        PAR_EN = par;
        if (1 + CHK <= cut) exp_sc.push_back(t0 + 1 + CHK);
        for (int b = 1; b <= DB; b++)
          if (1 + P * b + CHK <= cut) exp_ds.push_back(t0 + 1 + P * b + CHK);
        if (par && (1 + P * (1 + DB) + CHK <= cut)) exp_pc.push_back(t0 + 1 + P * (1 + DB) + CHK);
        if (eval_off - 1 <= cut) exp_tc.push_back(t0 + eval_off - 1);
        if (done && !(par && perr) && !serr) exp_dv.push_back(t0 + eval_off + 1);
      end
      if (k == 1) begin
        chk("cnt_en_at_T1", cnt_en, 1);
        chk("samp_en_at_T1", dat_samp_en, 1);
        chk("par_flag_clr", par_err_flag, 0);
        chk("stp_flag_clr", stp_err_flag, 0);
        PAR_EN = 1'($urandom_range(0, 1));
      end
      if (glitch && k == 8) chk("glitch_cnt_en_T8", cnt_en, 1);
      if (glitch && k == 9) chk("glitch_cnt_en_T9", cnt_en, 0);
      if (rst_k >= 0 && k == rst_k + 1) begin
        chk("rst_outputs", outs(), 0);
        RST = 1'b0;
        RX_IN = 1'b1;
      end else begin
        if (rst_k >= 0 && k == rst_k) RST = 1'b1;
        if (glitch)                RX_IN = (k < 3) ? 1'b0 : 1'b1;
        else if (j == 0)           RX_IN = 1'b0;
        else if (j <= DB)          RX_IN = data[j-1];
        else if (j == DB + 1 && par) RX_IN = ^data;
        else                       RX_IN = 1'b1;
      end
    end
    exp_pf = FLAGS_ON && done && par && perr;
    exp_sf = FLAGS_ON && done && serr;
  endtask

  initial begin
    int ta, tb2;
    logic [7:0] d;
    bit p, pe, se, gl;
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", outs(), 0);
    RST = 1'b0;
    idle(2);

    // 0xA5, no parity
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, -1, ta);
    idle(3);
    chk("a5_dv_at_T81", (obs_dv.size() > 0) ? obs_dv[0] - ta : -1, 81);
    chk("a5_deser_pulses", obs_ds.size(), 8);
    verify();

    // 0x3C with parity
    send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, -1, ta);
    idle(3);
    chk("3c_dv_at_T89", (obs_dv.size() > 0) ? obs_dv[0] - ta : -1, 89);
    chk("3c_par_chk_at_T79", (obs_pc.size() > 0) ? obs_pc[0] - ta : -1, 79);
    verify();

    // start glitch
    send(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, -1, ta);
    idle(3);
    verify();

    // stop error
    send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, -1, ta);
    idle(1);
    chk("stp_err_flag", stp_err_flag, FLAGS_ON);
    chk("par_err_flag_clean", par_err_flag, 0);
    idle(2);
    verify();

    // parity error
    send(8'h77, 1'b1, 1'b0, 1'b1, 1'b0, -1, ta);
    idle(1);
    chk("par_err_flag", par_err_flag, FLAGS_ON);
    idle(2);
    verify();

    // back-to-back: second start sampled in the first frame's data_valid cycle
    send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, -1, ta);
    send(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, -1, tb2);
    idle(3);
    chk("b2b_dv_gap", (obs_dv.size() == 2) ? obs_dv[1] - obs_dv[0] : -1, tb2 - ta);
    verify();

    // reset at edge 3 of data bit 4, then a clean frame
    send(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1 + P * 4 + 3, ta);
    idle(3);
    verify();
    send(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, -1, ta);
    idle(3);
    verify();

    // randomized frames with random gaps (0 = back-to-back)
    for (int n = 0; n < 10; n++) begin
      d  = 8'($urandom);
      p  = 1'($urandom_range(0, 1));
      pe = p && ($urandom_range(0, 3) == 0);
      se = ($urandom_range(0, 3) == 0);
      gl = ($urandom_range(0, 7) == 0);
      send(d, p, gl, pe, se, -1, ta);
      idle($urandom_range(0, 3));
    end
    idle(3);
    verify();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
